// File: rtl/scm_bist_pkg.sv
// rtl/scm_bist_pkg.sv - shared types and March C- table for the SCM BIST controller
package scm_bist_pkg;

    localparam int NUM_ELEM = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } bist_state_e;

    typedef enum logic [2:0] {
        RD0,
        RD1,
        WR0,
        WR1,
        NOP
    } bist_op_e;

    typedef struct packed {
        logic       down;
        logic [1:0] op_cnt;
        bist_op_e   op0;
        bist_op_e   op1;
    } march_elem_t;

    // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) down(r0)
    localparam march_elem_t MARCH_TABLE [NUM_ELEM] = '{
        '{1'b0, 2'd1, WR0, NOP},
        '{1'b0, 2'd2, RD0, WR1},
        '{1'b0, 2'd2, RD1, WR0},
        '{1'b1, 2'd2, RD0, WR1},
        '{1'b1, 2'd2, RD1, WR0},
        '{1'b1, 2'd1, RD0, NOP}
    };

endpackage

// File: rtl/scm_bist_addr_gen.sv
// rtl/scm_bist_addr_gen.sv - loadable up/down address counter for the March sequencer
module scm_bist_addr_gen #(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_WORDS  = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  load_down_i,
    input  logic                  step_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(NUM_WORDS - 1);

    logic down_q;

    // Load picks the element's start address and latches its direction; step moves one word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_o <= '0;
            down_q <= 1'b0;
        end else if (load_i) begin
            down_q <= load_down_i;
            addr_o <= load_down_i ? ADDR_MAX : '0;
        end else if (step_i) begin
            addr_o <= down_q ? addr_o - 1'b1 : addr_o + 1'b1;
        end
    end

    assign last_o = down_q ? (addr_o == '0) : (addr_o == ADDR_MAX);

endmodule

// File: rtl/scm_march_bist_ctrl.sv
// rtl/scm_march_bist_ctrl.sv - March C- BIST controller for one SCM register file test port
module scm_march_bist_ctrl
    import scm_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BYTE   = DATA_WIDTH / 8,
    parameter int NUM_WORDS  = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [2:0]            fail_elem_o,
    output logic                  BIST,
    output logic                  CSN_T,
    output logic                  WEN_T,
    output logic [ADDR_WIDTH-1:0] A_T,
    output logic [DATA_WIDTH-1:0] D_T,
    output logic [NUM_BYTE-1:0]   BE_T,
    input  logic [DATA_WIDTH-1:0] Q_T
);

    bist_state_e state_q, state_d;

    // Current op position: element, op slot within the address, and the op on the port
    logic [2:0] elem_q, elem_d, elem_inc;
    logic       idx_q, idx_d;
    bist_op_e   op_q, op_d;

    logic                  ag_load, ag_load_down, ag_step;
    logic [ADDR_WIDTH-1:0] ag_addr;
    logic                  ag_last;
    logic                  clear_res;
    logic                  active_d;

    // Read issued last cycle, compared against Q_T this cycle
    logic                  cmp_valid;
    logic                  cmp_exp;
    logic [ADDR_WIDTH-1:0] cmp_addr;
    logic [2:0]            cmp_elem;
    logic [DATA_WIDTH-1:0] exp_word;

    scm_bist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WORDS  (NUM_WORDS)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (ag_load),
        .load_down_i (ag_load_down),
        .step_i      (ag_step),
        .addr_o      (ag_addr),
        .last_o      (ag_last)
    );

    assign elem_inc = elem_q + 3'd1;
    assign exp_word = {DATA_WIDTH{cmp_exp}};
    assign A_T      = ag_addr;
    assign active_d = (state_d == RUN) || (state_d == DRAIN);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next op: walk op slots, then addresses, then elements, back to back
    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        idx_d        = idx_q;
        op_d         = NOP;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;
        clear_res    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d      = RUN;
                    elem_d       = 3'd0;
                    idx_d        = 1'b0;
                    op_d         = MARCH_TABLE[0].op0;
                    ag_load      = 1'b1;
                    ag_load_down = MARCH_TABLE[0].down;
                    clear_res    = 1'b1;
                end
            end
            RUN: begin
                if (!idx_q && MARCH_TABLE[elem_q].op_cnt == 2'd2) begin
                    idx_d = 1'b1;
                    op_d  = MARCH_TABLE[elem_q].op1;
                end else if (!ag_last) begin
                    idx_d   = 1'b0;
                    ag_step = 1'b1;
                    op_d    = MARCH_TABLE[elem_q].op0;
                end else if (elem_q != 3'(NUM_ELEM - 1)) begin
                    elem_d       = elem_inc;
                    idx_d        = 1'b0;
                    op_d         = MARCH_TABLE[elem_inc].op0;
                    ag_load      = 1'b1;
                    ag_load_down = MARCH_TABLE[elem_inc].down;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer position and registered test-port drive
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            elem_q <= 3'd0;
            idx_q  <= 1'b0;
            op_q   <= NOP;
            busy_o <= 1'b0;
            BIST   <= 1'b0;
            CSN_T  <= 1'b1;
            WEN_T  <= 1'b1;
            D_T    <= '0;
            BE_T   <= '0;
        end else begin
            elem_q <= elem_d;
            idx_q  <= idx_d;
            op_q   <= op_d;
            busy_o <= active_d;
            BIST   <= active_d;
            BE_T   <= active_d ? '1 : '0;
            CSN_T  <= (op_d == NOP);
            WEN_T  <= !((op_d == WR0) || (op_d == WR1));
            if (op_d == WR0) begin
                D_T <= '0;
            end else if (op_d == WR1) begin
                D_T <= '1;
            end
        end
    end

    // Read compare one cycle behind the port, first-failure capture, completion flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmp_valid   <= 1'b0;
            cmp_exp     <= 1'b0;
            cmp_addr    <= '0;
            cmp_elem    <= 3'd0;
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_elem_o <= 3'd0;
            done_o      <= 1'b0;
        end else begin
            cmp_valid <= ((op_q == RD0) || (op_q == RD1)) && !clear_res;
            cmp_exp   <= (op_q == RD1);
            cmp_addr  <= ag_addr;
            cmp_elem  <= elem_q;
            if (clear_res) begin
                fail_o      <= 1'b0;
                fail_addr_o <= '0;
                fail_elem_o <= 3'd0;
                done_o      <= 1'b0;
            end else begin
                if (cmp_valid && (Q_T != exp_word) && !fail_o) begin
                    fail_o      <= 1'b1;
                    fail_addr_o <= cmp_addr;
                    fail_elem_o <= cmp_elem;
                end
                if (state_q == DRAIN) begin
                    done_o <= 1'b1;
                end
            end
        end
    end

endmodule
